iadc_serial_rx: RTL and testbench

- Host-side counterpart to the incremental ADC's serial output.
- Issues the one-cycle `new_data` conversion request to the ADC, then collects the `DATA_W`-bit serial result clocked out on single-cycle `shift` strobes, MSB first.
- Presents each word on a valid/ready interface to the wishbone/logic-analyzer capture logic in the user project.
- Flags dropped words (overrun) and stalled transfers (timeout).

---
 rtl/iadc_pkg.sv | 13 +
 rtl/iadc_rx_shreg.sv | 41 ++++
 rtl/iadc_serial_rx.sv | 102 ++++++++++
 tb/tb_iadc_serial_rx.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iadc_pkg.sv
// Shared definitions for the incremental ADC serial interface, wrapper and register map.
package iadc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2
  } iadc_state_t;

  localparam int IADC_DATA_W         = 12;
  localparam int IADC_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/iadc_rx_shreg.sv
// MSB-first deserializer with bit counter; done fires on the strobe carrying the last bit.
// Latency: word/done are combinational from the current strobe, state updates on the next edge.
// Backpressure: none; the owner decides whether the completed word is kept.
module iadc_rx_shreg
  import iadc_pkg::*;
#(
  parameter int DATA_W = IADC_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              serial_data_in,
  output logic [DATA_W-1:0] word,
  output logic              done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;

  // word includes the bit arriving on this strobe, so the final strobe sees the full word
  assign word = {shreg[DATA_W-2:0], serial_data_in};
  assign done = shift_en && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg   <= word;
      bit_cnt <= done ? '0 : bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/iadc_serial_rx.sv
// Requests an ADC conversion, deserializes the strobed result and offers it on valid/ready.
// Latency: data_valid rises one cycle after the final strobe; new_data one cycle after start.
// Backpressure: a word completing while the slot is still held is dropped and flags overrun.
module iadc_serial_rx
  import iadc_pkg::*;
#(
  parameter int DATA_W         = IADC_DATA_W,
  parameter int TIMEOUT_CYCLES = IADC_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clr_flags,
  output logic              new_data,
  input  logic              shift_in,
  input  logic              serial_data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              overrun,
  output logic              timeout
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TIMEOUT_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  iadc_state_t       state, state_nxt;
  logic [TCNT_W-1:0] tcnt;
  logic              shift_en;
  logic              word_done;
  logic              tmo_hit;
  logic              slot_free;
  logic [DATA_W-1:0] word;

  assign new_data  = (state == REQ);
  assign busy      = (state != IDLE);
  assign shift_en  = (state == RECV) && shift_in;
  // a strobe in the limit cycle is a strobe, so only silent cycles can trip the timeout
  assign tmo_hit   = (state == RECV) && !shift_in && (tcnt >= TCNT_LAST);
  assign slot_free = !data_valid || data_ready;

  iadc_rx_shreg #(
    .DATA_W (DATA_W)
  ) u_shreg (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (state == REQ),
    .shift_en       (shift_en),
    .serial_data_in (serial_data_in),
    .word           (word),
    .done           (word_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     state_nxt = RECV;
      RECV:    if (word_done || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         tcnt <= '0;
    else if (state != RECV || shift_in) tcnt <= '0;
    else if (tcnt != TCNT_MAX)          tcnt <= tcnt + TCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (word_done && slot_free) begin
      data_out   <= word;
      data_valid <= 1'b1;
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

  // set has priority over clear so a coincident event is never lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (word_done && !slot_free) overrun <= 1'b1;
      else if (clr_flags)          overrun <= 1'b0;
      if (tmo_hit)                 timeout <= 1'b1;
      else if (clr_flags)          timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iadc_serial_rx.sv
// Self-checking bench for iadc_serial_rx: ADC model tasks drive strobes, a queue holds expected words.
module tb_iadc_serial_rx;

  localparam int DW  = 12;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          clr_flags = 1'b0;
  logic          shift_in = 1'b0;
  logic          serial_data_in = 1'b0;
  logic          data_ready = 1'b0;
  logic          new_data, data_valid, busy, overrun, timeout;
  logic [DW-1:0] data_out;

  int checks = 0;
  int failures = 0;
  int nd_cnt = 0;
  logic [DW-1:0] exp_q[$];

  iadc_serial_rx #(
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .clr_flags      (clr_flags),
    .new_data       (new_data),
    .shift_in       (shift_in),
    .serial_data_in (serial_data_in),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .busy           (busy),
    .overrun        (overrun),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (new_data === 1'b1) nd_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ADC model: wait for the request, then send nbits MSB-first, one strobe every gap cycles
  task automatic adc_bits(input logic [DW-1:0] w, input int nbits, input int gap,
                          input bit poke_start, input bit ready_last);
    int wait_cyc;
    wait_cyc = 0;
    while (new_data !== 1'b1 && wait_cyc < 8) begin
      step();
      wait_cyc++;
    end
    checks++;
    if (new_data !== 1'b1) begin
      failures++;
      $display("FAIL req_wait new_data=%b expected 1 within 8 cycles", new_data);
      return;
    end
    step();
    for (int i = 0; i < nbits; i++) begin
      for (int g = 1; g < gap; g++) begin
        start = poke_start;
        step();
      end
      start = 1'b0;
      shift_in = 1'b1;
      serial_data_in = w[DW-1-i];
      if (ready_last && i == nbits - 1) data_ready = 1'b1;
      step();
      shift_in = 1'b0;
      serial_data_in = 1'b0;
      if (ready_last && i == nbits - 1) data_ready = 1'b0;
    end
  endtask

  task automatic do_conv(input logic [DW-1:0] w, input int gap, input bit poke_start,
                         input bit ready_last);
    start = 1'b1;
    step();
    start = 1'b0;
    adc_bits(w, DW, gap, poke_start, ready_last);
  endtask

  task automatic pulse_ready();
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({new_data, data_valid, busy, overrun, timeout} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl nd/vld/busy/ovr/tmo=%b expected 00000",
               {new_data, data_valid, busy, overrun, timeout});
    end
    checks++;
    if (data_out !== '0) begin
      failures++;
      $display("FAIL reset_data data_out=%h expected 000", data_out);
    end
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [DW-1:0] exp;
    int nd0;
    data_ready = 1'b1;
    nd0 = nd_cnt;
    exp_q.push_back(12'hA5C);
    do_conv(12'hA5C, 3, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (data_valid !== 1'b1 || data_out !== exp) begin
      failures++;
      $display("FAIL single_word vld=%b data_out=%h expected vld=1 %h", data_valid, data_out, exp);
    end
    checks++;
    if (nd_cnt - nd0 != 1) begin
      failures++;
      $display("FAIL single_new_data cycles=%0d expected 1", nd_cnt - nd0);
    end
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL single_status busy=%b ovr=%b tmo=%b expected 0 0 0", busy, overrun, timeout);
    end
    step();
    checks++;
    if (data_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_consumed vld=%b expected 0", data_valid);
    end
    data_ready = 1'b0;
  endtask

  task automatic test_overrun();
    logic [DW-1:0] exp;
    exp_q.push_back(12'h123);
    do_conv(12'h123, 1, 1'b0, 1'b0);
    do_conv(12'hFFF, 1, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (data_valid !== 1'b1 || data_out !== exp || overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_hold vld=%b data_out=%h ovr=%b expected vld=1 %h ovr=1",
               data_valid, data_out, overrun, exp);
    end
    pulse_ready();
    checks++;
    if (data_valid !== 1'b0) begin
      failures++;
      $display("FAIL overrun_drain vld=%b expected 0", data_valid);
    end
    exp_q.push_back(12'h000);
    do_conv(12'h000, 1, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (data_valid !== 1'b1 || data_out !== exp) begin
      failures++;
      $display("FAIL overrun_next vld=%b data_out=%h expected vld=1 %h", data_valid, data_out, exp);
    end
    pulse_clr();
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear ovr=%b expected 0", overrun);
    end
    pulse_ready();
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] exp;
    exp_q.push_back(12'h800);
    do_conv(12'h800, 1, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (data_out !== exp) begin
      failures++;
      $display("FAIL same_first data_out=%h expected %h", data_out, exp);
    end
    exp_q.push_back(12'h001);
    do_conv(12'h001, 2, 1'b0, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (data_valid !== 1'b1 || data_out !== exp || overrun !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle vld=%b data_out=%h ovr=%b expected vld=1 %h ovr=0",
               data_valid, data_out, overrun, exp);
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] exp;
    logic [DW-1:0] held;
    held = data_out;
    start = 1'b1;
    step();
    start = 1'b0;
    adc_bits(12'hABC, 5, 1, 1'b0, 1'b0);
    repeat (TMO - 1) step();
    checks++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early tmo=%b busy=%b expected 0 1", timeout, busy);
    end
    step();
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_hit tmo=%b busy=%b expected 1 0", timeout, busy);
    end
    checks++;
    if (data_valid !== 1'b1 || data_out !== held) begin
      failures++;
      $display("FAIL timeout_slot vld=%b data_out=%h expected vld=1 %h", data_valid, data_out, held);
    end
    pulse_ready();
    pulse_clr();
    checks++;
    if (timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear tmo=%b expected 0", timeout);
    end
    exp_q.push_back(12'h3C3);
    do_conv(12'h3C3, 2, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (data_valid !== 1'b1 || data_out !== exp) begin
      failures++;
      $display("FAIL timeout_next vld=%b data_out=%h expected vld=1 %h", data_valid, data_out, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp;
    start = 1'b1;
    step();
    start = 1'b0;
    adc_bits(12'h7E1, 6, 1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({new_data, data_valid, busy, overrun, timeout} !== 5'b0 || data_out !== '0) begin
      failures++;
      $display("FAIL reset_mid nd/vld/busy/ovr/tmo=%b data_out=%h expected 00000 000",
               {new_data, data_valid, busy, overrun, timeout}, data_out);
    end
    step();
    rst_n = 1'b1;
    step();
    exp_q.push_back(12'h7E1);
    do_conv(12'h7E1, 1, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (data_valid !== 1'b1 || data_out !== exp) begin
      failures++;
      $display("FAIL reset_recover vld=%b data_out=%h expected vld=1 %h", data_valid, data_out, exp);
    end
    pulse_ready();
  endtask

  task automatic test_ignored();
    logic [DW-1:0] exp;
    int nd0;
    for (int i = 0; i < 3; i++) begin
      shift_in = 1'b1;
      serial_data_in = 1'b1;
      step();
      shift_in = 1'b0;
      serial_data_in = 1'b0;
      step();
    end
    checks++;
    if (busy !== 1'b0 || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL stray_shift busy=%b vld=%b expected 0 0", busy, data_valid);
    end
    nd0 = nd_cnt;
    exp_q.push_back(12'h5A6);
    do_conv(12'h5A6, 3, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (data_valid !== 1'b1 || data_out !== exp) begin
      failures++;
      $display("FAIL ignored_word vld=%b data_out=%h expected vld=1 %h", data_valid, data_out, exp);
    end
    repeat (3) step();
    checks++;
    if (nd_cnt - nd0 != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ignored_start new_data cycles=%0d busy=%b expected 1 0", nd_cnt - nd0, busy);
    end
    pulse_ready();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    data_ready = 1'b1;
    exp_q.push_back(12'h111);
    exp_q.push_back(12'h2EE);
    do_conv(12'h111, 1, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (data_valid !== 1'b1 || data_out !== exp) begin
      failures++;
      $display("FAIL b2b_first vld=%b data_out=%h expected vld=1 %h", data_valid, data_out, exp);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (new_data !== 1'b1) begin
      failures++;
      $display("FAIL b2b_request new_data=%b expected 1", new_data);
    end
    adc_bits(12'h2EE, DW, 1, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (data_valid !== 1'b1 || data_out !== exp) begin
      failures++;
      $display("FAIL b2b_second vld=%b data_out=%h expected vld=1 %h", data_valid, data_out, exp);
    end
    step();
    data_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_same_cycle();
    test_timeout();
    test_reset_mid();
    test_ignored();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left entries=%0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
